reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
//  Write-back arbiter and scoreboard driving the register-file write port (WAddr/WData/Wen).
//  Merges two result sources: single-cycle ALU results, and variable-latency load returns from the data-memory path.
//  Tracks outstanding load destinations so decode can stall on RAW hazards.
//  Sits between the EX/MEM stages and the register file.
// PARAMETERS
//  DSIZE  16  data width (matches `DSIZE)
//  RSIZE  4   register address width (matches `RSIZE)
//  NREG   16  number of architectural registers (2**RSIZE)
// PORTS
//  Clock       in   1      clock, all state on rising edge
//  Reset       in   1      synchronous, active-low
//  Alu_Valid   in   1      ALU result present this cycle
//  Alu_Addr    in   RSIZE  ALU destination register
//  Alu_Data    in   DSIZE  ALU result
//  Ld_Valid    in   1      load data returning
//  Ld_Addr     in   RSIZE  load destination register
//  Ld_Data     in   DSIZE  load data
//  Ld_Ready    out  1      load return accepted (Ld_Valid & Ld_Ready = transfer)
//  Alu_Stall   out  1      upstream must not present Alu_Valid this cycle
//  Issue_Valid in   1      load issued to memory; mark Issue_Addr pending
//  Issue_Addr  in   RSIZE  destination of the issued load
//  RAddr1      in   RSIZE  decode read address 1 (hazard check)
//  RAddr2      in   RSIZE  decode read address 2 (hazard check)
//  Busy1       out  1      RAddr1 has an outstanding load (comb)
//  Busy2       out  1      RAddr2 has an outstanding load (comb)
//  WAddr       out  RSIZE  register-file write address (registered)
//  WData       out  DSIZE  register-file write data (registered)
//  Wen         out  1      register-file write enable (registered)
// BEHAVIOUR
//  Reset (Reset==0 at posedge): Wen=0, WAddr=0, WData=0, Pending=0, hold FSM=EMPTY.
//   Resulting outputs: Ld_Ready=1, Alu_Stall=0, Busy1=Busy2=0.
//  Latency: accepted result -> Wen/WAddr/WData one cycle later; Wen is high for exactly 1 cycle per write.
//  Hold FSM, state EMPTY:
//   - Ld_Ready=1, Alu_Stall=0.
//   - Alu_Valid only -> write ALU result.
//   - Ld_Valid only -> write load.
//   - Both valid -> write ALU; capture load into hold regs; go to HELD.
//  Hold FSM, state HELD:
//   - Ld_Ready=0, Alu_Stall=1.
//   - Held load is written next cycle; go to EMPTY.
//   - Alu_Valid in HELD is a protocol violation; sim assertion fires and the ALU result is dropped.
//  R0 rule: any write with address 0 produces Wen=0 (R0 is constant 0).
//   - Its pending bit is still cleared.
//   - WAddr/WData hold their previous values.
//  R15 is written normally (PC/address register); no special case here.
//  Scoreboard Pending[NREG-1:0]:
//   - Set bit Issue_Addr on Issue_Valid, except when Issue_Addr==0.
//   - Clear bit Ld_Addr when the load is accepted (Ld_Valid & Ld_Ready), not when it is written from hold.
//   - Set and clear of the same bit in the same cycle -> set wins (new load outstanding).
//   - Ld_Valid for a non-pending address is legal and is written normally.
//  Busy1/Busy2 = Pending[RAddrN]; register-file bypass makes same-cycle write data visible, so no extra term.
//  Reset mid-operation: held load is discarded and Pending cleared; the memory side must also be reset.
// STRUCTURE
//  Shared defines header: `DSIZE, `RSIZE, hold FSM encodings (WB_EMPTY=1'b0, WB_HELD=1'b1).
//  One natural sub-module: wb_hold_buf (1-entry load hold register + FSM, outputs Ld_Ready/Alu_Stall).
//  Scoreboard and output register stay in reg_writeback.
// TESTING
//  1. Reset low 2 cycles -> Wen=0, Pending=0, Ld_Ready=1, Alu_Stall=0.
//  2. Alu_Valid, Addr=3, Data=16'hBEEF -> next cycle Wen=1, WAddr=3, WData=BEEF; following cycle Wen=0.
//  3. Issue_Valid Addr=5, RAddr1=5 -> Busy1=1 next cycle.
//     Ld_Valid Addr=5, Data=16'h1234 -> Busy1=0 next cycle; Wen=1, WAddr=5, WData=1234.
//  4. Same-cycle ALU(2,16'h0011) + Ld(7,16'h0077) -> cycle+1 writes R2, Ld_Ready=0, Alu_Stall=1;
//     cycle+2 writes R7, Ld_Ready=1.
//  5. Alu_Valid, Addr=0, Data=16'hFFFF -> Wen stays 0; Issue_Valid Addr=0 -> Pending unchanged.
//  6. Reset asserted while HELD (load to R9 held) -> R9 never written; Pending=0; FSM=EMPTY.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared widths, hold-FSM encoding and result bundle
// for the write-back stage.
package reg_writeback_pkg;
  localparam int DSIZE = 16;
  localparam int RSIZE = 4;
  localparam int NREG  = 1 << RSIZE;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_HELD  = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [RSIZE-1:0] addr;
    logic [DSIZE-1:0] data;
  } wb_res_t;
endpackage

// File: rtl/reg_writeback_if.sv
// Result buses into write-back: ALU results and
// load returns with their flow-control replies.
interface reg_writeback_if;
  import reg_writeback_pkg::*;

  logic             Alu_Valid;
  logic [RSIZE-1:0] Alu_Addr;
  logic [DSIZE-1:0] Alu_Data;
  logic             Alu_Stall;
  logic             Ld_Valid;
  logic [RSIZE-1:0] Ld_Addr;
  logic [DSIZE-1:0] Ld_Data;
  logic             Ld_Ready;

  modport master (
    output Alu_Valid, Alu_Addr, Alu_Data,
    output Ld_Valid, Ld_Addr, Ld_Data,
    input  Alu_Stall, Ld_Ready
  );

  modport slave (
    input  Alu_Valid, Alu_Addr, Alu_Data,
    input  Ld_Valid, Ld_Addr, Ld_Data,
    output Alu_Stall, Ld_Ready
  );
endinterface

// File: rtl/reg_writeback_hold_buf.sv
// One-entry load hold register; parks a load that
// collided with an ALU result for one cycle.
module wb_hold_buf
  import reg_writeback_pkg::*;
(
  input  logic    Clock,
  input  logic    Reset,
  input  logic    alu_valid,
  input  logic    ld_valid,
  input  wb_res_t ld_res,
  output logic    ld_ready,
  output logic    alu_stall,
  output logic    held,
  output wb_res_t held_res
);
  wb_state_t state;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= WB_EMPTY;
      ld_ready  <= 1'b1;
      alu_stall <= 1'b0;
      held_res  <= '0;
    end else begin
      unique case (state)
        WB_EMPTY: begin
          if (alu_valid && ld_valid) begin
            state     <= WB_HELD;
            held_res  <= ld_res;
            ld_ready  <= 1'b0;
            alu_stall <= 1'b1;
          end
        end
        WB_HELD: begin
          state     <= WB_EMPTY;
          ld_ready  <= 1'b1;
          alu_stall <= 1'b0;
        end
      endcase
    end
  end

  assign held = (state == WB_HELD);

  // ALU must honour the stall; a result arriving now is dropped
  a_no_alu_when_held: assert property (
    @(posedge Clock) disable iff (!Reset)
    !(held && alu_valid)
  ) else $error("ALU result presented while load held");
endmodule

// File: rtl/reg_writeback.sv
// Write-back arbiter and load scoreboard driving
// the register-file write port.
module reg_writeback
  import reg_writeback_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  reg_writeback_if.slave   res,
  input  logic             Issue_Valid,
  input  logic [RSIZE-1:0] Issue_Addr,
  input  logic [RSIZE-1:0] RAddr1,
  input  logic [RSIZE-1:0] RAddr2,
  output logic             Busy1,
  output logic             Busy2,
  output logic [RSIZE-1:0] WAddr,
  output logic [DSIZE-1:0] WData,
  output logic             Wen
);
  wb_res_t alu_res;
  wb_res_t ld_res;
  wb_res_t held_res;
  wb_res_t wr;
  logic    held;
  logic    ld_acc;
  logic    sel_held;
  logic    sel_alu;
  logic    sel_ld;
  logic    wr_en;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nx;

  assign alu_res = {res.Alu_Addr, res.Alu_Data};
  assign ld_res  = {res.Ld_Addr, res.Ld_Data};
  assign ld_acc  = res.Ld_Valid && res.Ld_Ready;

  wb_hold_buf u_hold (
    .Clock     (Clock),
    .Reset     (Reset),
    .alu_valid (res.Alu_Valid),
    .ld_valid  (res.Ld_Valid),
    .ld_res    (ld_res),
    .ld_ready  (res.Ld_Ready),
    .alu_stall (res.Alu_Stall),
    .held      (held),
    .held_res  (held_res)
  );

  assign sel_held = held;
  assign sel_alu  = !held && res.Alu_Valid;
  assign sel_ld   = !held && !res.Alu_Valid && ld_acc;

  always_comb begin
    wr_en = 1'b0;
    wr    = alu_res;
    unique case (1'b1)
      sel_held: begin
        wr_en = 1'b1;
        wr    = held_res;
      end
      sel_alu: begin
        wr_en = 1'b1;
        wr    = alu_res;
      end
      sel_ld: begin
        wr_en = 1'b1;
        wr    = ld_res;
      end
      default: ;
    endcase
  end

  // Set after clear so a reissue to the same reg wins
  always_comb begin
    pending_nx = pending;
    if (ld_acc)
      pending_nx[res.Ld_Addr] = 1'b0;
    if (Issue_Valid && Issue_Addr != '0)
      pending_nx[Issue_Addr] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Wen     <= 1'b0;
      WAddr   <= '0;
      WData   <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nx;
      Wen     <= wr_en && (wr.addr != '0);
      if (wr_en && wr.addr != '0) begin
        WAddr <= wr.addr;
        WData <= wr.data;
      end
    end
  end

  assign Busy1 = pending[RAddr1];
  assign Busy2 = pending[RAddr2];
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a queue-based
// reference model checked every cycle.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             Issue_Valid;
  logic [RSIZE-1:0] Issue_Addr;
  logic [RSIZE-1:0] RAddr1;
  logic [RSIZE-1:0] RAddr2;
  logic             Busy1;
  logic             Busy2;
  logic [RSIZE-1:0] WAddr;
  logic [DSIZE-1:0] WData;
  logic             Wen;

  int checks = 0;
  int errors = 0;

  reg_writeback_if bus ();

  reg_writeback dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .res         (bus.slave),
    .Issue_Valid (Issue_Valid),
    .Issue_Addr  (Issue_Addr),
    .RAddr1      (RAddr1),
    .RAddr2      (RAddr2),
    .Busy1       (Busy1),
    .Busy2       (Busy2),
    .WAddr       (WAddr),
    .WData       (WData),
    .Wen         (Wen)
  );

  always #5 Clock = ~Clock;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: results queue in arrival order, one
  // write retires per cycle; loads accepted only when
  // nothing is waiting.
  wb_res_t          q[$];
  bit               mpend[NREG];
  logic             mwen;
  logic [RSIZE-1:0] mwaddr;
  logic [DSIZE-1:0] mwdata;
  logic             mready;

  always @(posedge Clock) begin
    wb_res_t w;
    if (!Reset) begin
      q.delete();
      for (int i = 0; i < NREG; i++) mpend[i] = 1'b0;
      mwen   = 1'b0;
      mwaddr = '0;
      mwdata = '0;
      mready = 1'b1;
    end else begin
      if (bus.Alu_Valid && mready)
        q.push_back({bus.Alu_Addr, bus.Alu_Data});
      if (bus.Ld_Valid && mready) begin
        q.push_back({bus.Ld_Addr, bus.Ld_Data});
        mpend[bus.Ld_Addr] = 1'b0;
      end
      if (Issue_Valid && Issue_Addr != 0)
        mpend[Issue_Addr] = 1'b1;
      mwen = 1'b0;
      if (q.size() > 0) begin
        w = q.pop_front();
        if (w.addr != 0) begin
          mwen   = 1'b1;
          mwaddr = w.addr;
          mwdata = w.data;
        end
      end
      mready = (q.size() == 0);
    end
    #1;
    chk("m_wen",   32'(Wen),           32'(mwen));
    chk("m_waddr", 32'(WAddr),         32'(mwaddr));
    chk("m_wdata", 32'(WData),         32'(mwdata));
    chk("m_ready", 32'(bus.Ld_Ready),  32'(mready));
    chk("m_stall", 32'(bus.Alu_Stall), 32'(!mready));
    chk("m_busy1", 32'(Busy1),         32'(mpend[RAddr1]));
    chk("m_busy2", 32'(Busy2),         32'(mpend[RAddr2]));
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic idle();
    bus.Alu_Valid = 1'b0;
    bus.Ld_Valid  = 1'b0;
    Issue_Valid   = 1'b0;
  endtask

  task automatic alu(input int a, input int d);
    bus.Alu_Valid = 1'b1;
    bus.Alu_Addr  = RSIZE'(a);
    bus.Alu_Data  = DSIZE'(d);
  endtask

  task automatic ld(input int a, input int d);
    bus.Ld_Valid = 1'b1;
    bus.Ld_Addr  = RSIZE'(a);
    bus.Ld_Data  = DSIZE'(d);
  endtask

  task automatic iss(input int a);
    Issue_Valid = 1'b1;
    Issue_Addr  = RSIZE'(a);
  endtask

  initial begin
    idle();
    bus.Alu_Addr = '0;
    bus.Alu_Data = '0;
    bus.Ld_Addr  = '0;
    bus.Ld_Data  = '0;
    Issue_Addr   = '0;
    RAddr1       = '0;
    RAddr2       = '0;

    tick();
    tick();
    chk("rst_wen",   32'(Wen),           0);
    chk("rst_waddr", 32'(WAddr),         0);
    chk("rst_ready", 32'(bus.Ld_Ready),  1);
    chk("rst_stall", 32'(bus.Alu_Stall), 0);
    Reset = 1'b1;

    tick();
    alu(3, 'hBEEF);
    tick();
    idle();
    chk("alu_wen",   32'(Wen),   1);
    chk("alu_waddr", 32'(WAddr), 3);
    chk("alu_wdata", 32'(WData), 'hBEEF);
    tick();
    chk("alu_pulse", 32'(Wen), 0);

    iss(5);
    RAddr1 = 4'd5;
    tick();
    idle();
    chk("iss_busy1", 32'(Busy1), 1);
    ld(5, 'h1234);
    tick();
    idle();
    chk("ld_busy1", 32'(Busy1), 0);
    chk("ld_wen",   32'(Wen),   1);
    chk("ld_waddr", 32'(WAddr), 5);
    chk("ld_wdata", 32'(WData), 'h1234);

    alu(2, 'h0011);
    ld(7, 'h0077);
    tick();
    idle();
    chk("col_waddr", 32'(WAddr),         2);
    chk("col_wdata", 32'(WData),         'h0011);
    chk("col_ready", 32'(bus.Ld_Ready),  0);
    chk("col_stall", 32'(bus.Alu_Stall), 1);
    tick();
    chk("held_wen",   32'(Wen),          1);
    chk("held_waddr", 32'(WAddr),        7);
    chk("held_wdata", 32'(WData),        'h0077);
    chk("held_ready", 32'(bus.Ld_Ready), 1);

    alu(0, 'hFFFF);
    tick();
    idle();
    chk("r0_wen",   32'(Wen),   0);
    chk("r0_wdata", 32'(WData), 'h0077);
    iss(0);
    RAddr2 = 4'd0;
    tick();
    idle();
    chk("r0_busy2", 32'(Busy2), 0);

    alu(15, 'hABCD);
    tick();
    idle();
    chk("r15_waddr", 32'(WAddr), 15);
    chk("r15_wdata", 32'(WData), 'hABCD);

    iss(6);
    RAddr1 = 4'd6;
    tick();
    iss(6);
    ld(6, 'h0666);
    tick();
    idle();
    chk("sc_busy1", 32'(Busy1), 1);
    chk("sc_waddr", 32'(WAddr), 6);

    ld(11, 'h0BBB);
    tick();
    idle();
    chk("np_wen",   32'(Wen),   1);
    chk("np_waddr", 32'(WAddr), 11);
    chk("np_wdata", 32'(WData), 'h0BBB);

    iss(12);
    RAddr1 = 4'd12;
    RAddr2 = 4'd6;
    tick();
    idle();
    chk("r12_busy1", 32'(Busy1), 1);
    alu(4, 'h0044);
    ld(9, 'h0999);
    tick();
    idle();
    Reset = 1'b0;
    chk("h9_stall", 32'(bus.Alu_Stall), 1);
    chk("h9_waddr", 32'(WAddr),         4);
    tick();
    Reset = 1'b1;
    chk("mrst_wen",   32'(Wen),          0);
    chk("mrst_waddr", 32'(WAddr),        0);
    chk("mrst_busy1", 32'(Busy1),        0);
    chk("mrst_busy2", 32'(Busy2),        0);
    chk("mrst_ready", 32'(bus.Ld_Ready), 1);
    tick();
    chk("no_r9_wen", 32'(Wen), 0);
    tick();
    chk("no_r9_wen2", 32'(Wen), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
